// File: rtl/vx_csr_regfile_pkg.sv
// rtl/vx_csr_regfile_pkg.sv - shared types and CSR address map for vx_csr_regfile
package vx_csr_regfile_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_FFLAGS    = 12'h001;
    localparam logic [11:0] CSR_FRM       = 12'h002;
    localparam logic [11:0] CSR_FCSR      = 12'h003;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MAX_XLEN      = 64;
    localparam int MAX_SCRATCH   = 16;
    localparam int MAX_FLAG_BITS = 8;
    localparam int MAX_FRM_BITS  = 8;

    // Sized for the widest legal configuration; the regfile only touches the low bits.
    typedef struct packed {
        logic [MAX_FLAG_BITS-1:0]               fflags;
        logic [MAX_FRM_BITS-1:0]                frm;
        logic [MAX_XLEN-1:0]                    mscratch;
        logic [MAX_SCRATCH-1:0][MAX_XLEN-1:0]   scratch;
    } csr_warp_state_t;

endpackage

// File: rtl/vx_csr_ctr_snapshot.sv
// rtl/vx_csr_ctr_snapshot.sv - per-warp hi-half counter snapshot for coherent 64-bit reads
module vx_csr_ctr_snapshot
    import vx_csr_regfile_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      live_hi,
    input  logic             lo_rd,
    input  logic             hi_rd,
    input  logic [WID_W-1:0] wid,
    output logic [31:0]      hi_data
);

    logic [31:0]          snap_q [NUM_WARPS];
    logic [NUM_WARPS-1:0] snap_vld_q;

    assign hi_data = snap_vld_q[wid] ? snap_q[wid] : live_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                snap_q[w] <= '0;
            end
            snap_vld_q <= '0;
        end else if (lo_rd) begin
            snap_q[wid]     <= live_hi;
            snap_vld_q[wid] <= 1'b1;
        end else if (hi_rd) begin
            snap_vld_q[wid] <= 1'b0;
        end
    end

endmodule

// File: rtl/vx_csr_regfile.sv
// rtl/vx_csr_regfile.sv - per-warp CSR register file with atomic RMW request/response port
module vx_csr_regfile
    import vx_csr_regfile_pkg::*;
#(
    parameter int          NUM_WARPS      = 4,
    parameter int          XLEN           = 32,
    parameter int          NUM_SCRATCH    = 4,
    parameter logic [11:0] SCRATCH_BASE   = 12'h7C0,
    parameter int          NUM_FLAG_PORTS = 2,
    parameter int          FLAGS_BITS     = 5,
    parameter int          FRM_BITS       = 3,
    parameter int          CTR_BITS       = 64,
    parameter int          WID_W          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
)(
    input  logic                               clk,
    input  logic                               reset,
    input  logic [XLEN-1:0]                    startup_arg,
    input  logic [CTR_BITS-1:0]                cycles,
    input  logic [CTR_BITS-1:0]                instret,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [WID_W-1:0]                   req_wid,
    input  logic [11:0]                        req_addr,
    input  logic [1:0]                         req_op,
    input  logic [XLEN-1:0]                    req_data,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [XLEN-1:0]                    rsp_data,
    output logic                               rsp_error,
    input  logic [NUM_FLAG_PORTS-1:0]          flag_valid,
    input  logic [NUM_FLAG_PORTS*WID_W-1:0]    flag_wid,
    input  logic [NUM_FLAG_PORTS*FLAGS_BITS-1:0] flag_bits,
    input  logic [NUM_FLAG_PORTS*WID_W-1:0]    frm_rd_wid,
    output logic [NUM_FLAG_PORTS*FRM_BITS-1:0] frm_rd_data
);

    csr_warp_state_t       warp_q [NUM_WARPS];
    csr_op_e               op;
    logic                  fire;
    logic [11:0]           scr_off;
    logic                  is_fflags, is_frm, is_fcsr, is_msc, is_scr;
    logic                  is_mcyc, is_mret, is_mcych, is_mreth;
    logic                  rw_hit, ro_hit, do_write, err, wr_en;
    logic [XLEN-1:0]       old_val, new_val;
    logic [63:0]           cyc64, ret64;
    logic [31:0]           cyc_hi_rd, ret_hi_rd;
    logic [FLAGS_BITS-1:0] acc [NUM_WARPS];

    assign op        = csr_op_e'(req_op);
    assign req_ready = ~rsp_valid | rsp_ready;
    assign fire      = req_valid & req_ready;
    assign cyc64     = 64'(cycles);
    assign ret64     = 64'(instret);

    always_comb begin
        scr_off   = req_addr - SCRATCH_BASE;
        is_fflags = (req_addr == CSR_FFLAGS);
        is_frm    = (req_addr == CSR_FRM);
        is_fcsr   = (req_addr == CSR_FCSR);
        is_msc    = (req_addr == CSR_MSCRATCH);
        is_scr    = (req_addr >= SCRATCH_BASE) && (scr_off < 12'(NUM_SCRATCH));
        is_mcyc   = (req_addr == CSR_MCYCLE);
        is_mret   = (req_addr == CSR_MINSTRET);
        is_mcych  = (XLEN == 32) && (req_addr == CSR_MCYCLEH);
        is_mreth  = (XLEN == 32) && (req_addr == CSR_MINSTRETH);
        rw_hit    = is_fflags | is_frm | is_fcsr | is_msc | is_scr;
        ro_hit    = is_mcyc | is_mret | is_mcych | is_mreth;
        // RS/RC with a zero mask is a pure read and therefore legal on read-only CSRs
        do_write  = (op == CSR_OP_RW) ||
                    (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (req_data != '0));
        err       = ~(rw_hit | ro_hit) | (ro_hit & do_write);
        wr_en     = fire & ~err & do_write;
    end

    always_comb begin
        old_val = '0;
        if (is_fflags)
            old_val = XLEN'(warp_q[req_wid].fflags[FLAGS_BITS-1:0]);
        else if (is_frm)
            old_val = XLEN'(warp_q[req_wid].frm[FRM_BITS-1:0]);
        else if (is_fcsr)
            old_val = XLEN'({warp_q[req_wid].frm[FRM_BITS-1:0],
                             warp_q[req_wid].fflags[FLAGS_BITS-1:0]});
        else if (is_msc)
            old_val = warp_q[req_wid].mscratch[XLEN-1:0];
        else if (is_scr)
            old_val = warp_q[req_wid].scratch[scr_off[3:0]][XLEN-1:0];
        else if (is_mcyc)
            old_val = cyc64[XLEN-1:0];
        else if (is_mret)
            old_val = ret64[XLEN-1:0];
        else if (is_mcych)
            old_val = XLEN'(cyc_hi_rd);
        else if (is_mreth)
            old_val = XLEN'(ret_hi_rd);

        new_val = old_val;
        case (op)
            CSR_OP_RW: new_val = req_data;
            CSR_OP_RS: new_val = old_val | req_data;
            CSR_OP_RC: new_val = old_val & ~req_data;
            default:   new_val = old_val;
        endcase
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            acc[w] = '0;
            for (int p = 0; p < NUM_FLAG_PORTS; p++) begin
                if (flag_valid[p] && (flag_wid[p*WID_W +: WID_W] == WID_W'(w)))
                    acc[w] = acc[w] | flag_bits[p*FLAGS_BITS +: FLAGS_BITS];
            end
        end
    end

    // Later assignments win, so a CSR write to fflags overrides that cycle's accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                warp_q[w]          <= '0;
                warp_q[w].mscratch <= MAX_XLEN'(startup_arg);
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                warp_q[w].fflags <= warp_q[w].fflags | MAX_FLAG_BITS'(acc[w]);
                if (wr_en && (req_wid == WID_W'(w))) begin
                    if (is_fflags || is_fcsr)
                        warp_q[w].fflags <= MAX_FLAG_BITS'(new_val[FLAGS_BITS-1:0]);
                    if (is_frm)
                        warp_q[w].frm <= MAX_FRM_BITS'(new_val[FRM_BITS-1:0]);
                    if (is_fcsr)
                        warp_q[w].frm <= MAX_FRM_BITS'(new_val[FLAGS_BITS +: FRM_BITS]);
                    if (is_msc)
                        warp_q[w].mscratch <= MAX_XLEN'(new_val);
                    if (is_scr)
                        warp_q[w].scratch[scr_off[3:0]] <= MAX_XLEN'(new_val);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= err ? '0 : old_val;
            rsp_error <= err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_comb begin
        frm_rd_data = '0;
        for (int p = 0; p < NUM_FLAG_PORTS; p++) begin
            frm_rd_data[p*FRM_BITS +: FRM_BITS] =
                warp_q[frm_rd_wid[p*WID_W +: WID_W]].frm[FRM_BITS-1:0];
        end
    end

    vx_csr_ctr_snapshot #(
        .NUM_WARPS (NUM_WARPS),
        .WID_W     (WID_W)
    ) u_cyc_snap (
        .clk     (clk),
        .reset   (reset),
        .live_hi (cyc64[63:32]),
        .lo_rd   (fire & ~err & is_mcyc),
        .hi_rd   (fire & ~err & is_mcych),
        .wid     (req_wid),
        .hi_data (cyc_hi_rd)
    );

    vx_csr_ctr_snapshot #(
        .NUM_WARPS (NUM_WARPS),
        .WID_W     (WID_W)
    ) u_ret_snap (
        .clk     (clk),
        .reset   (reset),
        .live_hi (ret64[63:32]),
        .lo_rd   (fire & ~err & is_mret),
        .hi_rd   (fire & ~err & is_mreth),
        .wid     (req_wid),
        .hi_data (ret_hi_rd)
    );

endmodule
